// File: rtl/func_seq_pkg.sv
// Shared constants for the func_seq instruction sequencer: FSM state codes,
// MSP430 register-mode opcode fields and functional-unit select prefixes.
package func_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_READ = 3'd1;
  localparam state_t ST_EXEC = 3'd2;
  localparam state_t ST_WB   = 3'd3;
  localparam state_t ST_TRAP = 3'd4;

  localparam logic [3:0] FS_SHIFT    = 4'b1000;
  localparam logic [5:0] FMT2_PREFIX = 6'b000100;

  localparam logic [2:0] OPC_RRC  = 3'd0;
  localparam logic [2:0] OPC_SWPB = 3'd1;
  localparam logic [2:0] OPC_RRA  = 3'd2;
  localparam logic [2:0] OPC_SXT  = 3'd3;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;
  localparam logic [3:0] OP_BIC = 4'hC;
  localparam logic [3:0] OP_BIS = 4'hD;

  function automatic logic is_fmt1(input logic [3:0] op);
    return op >= OP_MOV;
  endfunction

endpackage

// File: rtl/func_seq_dec.sv
// Combinational decode of a latched MSP430 word into functional-unit select,
// operand registers and write-back enables; non-register modes are illegal.
module func_seq_dec
  import func_seq_pkg::*;
(
  input  logic [15:0] instr,
  output logic [5:0]  fs,
  output logic        bw,
  output logic [3:0]  src,
  output logic [3:0]  dst,
  output logic        rf_wr,
  output logic        sr_wr,
  output logic        illegal
);

  logic [3:0] op;
  assign op = instr[15:12];

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    fs      = '0;
    bw      = 1'b0;
    src     = '0;
    dst     = '0;
    rf_wr   = 1'b0;
    sr_wr   = 1'b0;
    illegal = 1'b1;
    if (is_fmt1(op)) begin
      fs      = {2'b00, op};
      bw      = instr[6];
      src     = instr[11:8];
      dst     = instr[3:0];
      illegal = instr[7] | (instr[5:4] != 2'b00);
      rf_wr   = !(op == OP_CMP || op == OP_BIT);
      sr_wr   = !(op == OP_MOV || op == OP_BIC || op == OP_BIS);
    end else if (instr[15:10] == FMT2_PREFIX) begin
      fs      = {FS_SHIFT, instr[8:7]};
      bw      = instr[6];
      src     = instr[3:0];
      dst     = instr[3:0];
      // opc above SXT (PUSH, CALL, RETI) has instr[9] set
      illegal = instr[9] | (instr[5:4] != 2'b00);
      rf_wr   = 1'b1;
      sr_wr   = (instr[9:7] != OPC_SWPB);
    end
    if (illegal) begin
      rf_wr = 1'b0;
      sr_wr = 1'b0;
    end
  end

endmodule

// File: rtl/func_seq.sv
// Single-issue IDLE/READ/EXEC/WB sequencer driving the functional unit.
// Optional FUNC_SEQ_ILLEGAL_TRAP_EN: illegal words lock into TRAP until rst.
module func_seq
  import func_seq_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  output logic [3:0]      rf_src_addr,
  output logic [3:0]      rf_dst_addr,
  input  logic [SIZE-1:0] rf_src_data,
  input  logic [SIZE-1:0] rf_dst_data,
  output logic [SIZE-1:0] fu_a,
  output logic [SIZE-1:0] fu_b,
  output logic [5:0]      fu_fs,
  output logic            fu_cin,
  output logic            fu_bw,
  input  logic [SIZE-1:0] fu_f,
  input  logic [3:0]      fu_cvnz,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [SIZE-1:0] rf_wdata,
  output logic            sr_we,
  output logic [3:0]      sr_cvnz,
  input  logic            sr_c,
  output logic            done,
  output logic            err
);

  state_t          state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic [SIZE-1:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d, f_q, f_d;
  logic [5:0]      fu_fs_q, fu_fs_d;
  logic            fu_bw_q, fu_bw_d, fu_cin_q, fu_cin_d;
  logic            bw_q, bw_d, rf_wr_q, rf_wr_d, sr_wr_q, sr_wr_d, illegal_q, illegal_d;
  logic [3:0]      waddr_q, waddr_d, cvnz_q, cvnz_d;

  logic [5:0] dec_fs;
  logic       dec_bw, dec_rf_wr, dec_sr_wr, dec_illegal;
  logic [3:0] dec_src, dec_dst;

  func_seq_dec u_dec (
    .instr   (instr_q),
    .fs      (dec_fs),
    .bw      (dec_bw),
    .src     (dec_src),
    .dst     (dec_dst),
    .rf_wr   (dec_rf_wr),
    .sr_wr   (dec_sr_wr),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    fu_a_d    = fu_a_q;
    fu_b_d    = fu_b_q;
    fu_fs_d   = fu_fs_q;
    fu_bw_d   = fu_bw_q;
    fu_cin_d  = fu_cin_q;
    bw_d      = bw_q;
    rf_wr_d   = rf_wr_q;
    sr_wr_d   = sr_wr_q;
    illegal_d = illegal_q;
    waddr_d   = waddr_q;
    f_d       = f_q;
    cvnz_d    = cvnz_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        fu_a_d    = rf_src_data;
        fu_b_d    = rf_dst_data;
        fu_fs_d   = dec_fs;
        fu_bw_d   = dec_bw;
        fu_cin_d  = sr_c;
        bw_d      = dec_bw;
        rf_wr_d   = dec_rf_wr;
        sr_wr_d   = dec_sr_wr;
        illegal_d = dec_illegal;
        waddr_d   = dec_dst;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        f_d      = fu_f;
        cvnz_d   = fu_cvnz;
        // operands are only presented to the functional unit during EXEC
        fu_a_d   = '0;
        fu_b_d   = '0;
        fu_fs_d  = '0;
        fu_bw_d  = 1'b0;
        fu_cin_d = 1'b0;
        state_d  = ST_WB;
      end
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
      ST_WB:   state_d = illegal_q ? ST_TRAP : ST_IDLE;
      ST_TRAP: state_d = ST_TRAP;
`else
      ST_WB:   state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      fu_a_q    <= '0;
      fu_b_q    <= '0;
      fu_fs_q   <= '0;
      fu_bw_q   <= 1'b0;
      fu_cin_q  <= 1'b0;
      bw_q      <= 1'b0;
      rf_wr_q   <= 1'b0;
      sr_wr_q   <= 1'b0;
      illegal_q <= 1'b0;
      waddr_q   <= '0;
      f_q       <= '0;
      cvnz_q    <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      fu_a_q    <= fu_a_d;
      fu_b_q    <= fu_b_d;
      fu_fs_q   <= fu_fs_d;
      fu_bw_q   <= fu_bw_d;
      fu_cin_q  <= fu_cin_d;
      bw_q      <= bw_d;
      rf_wr_q   <= rf_wr_d;
      sr_wr_q   <= sr_wr_d;
      illegal_q <= illegal_d;
      waddr_q   <= waddr_d;
      f_q       <= f_d;
      cvnz_q    <= cvnz_d;
    end
  end

  logic in_read, in_wb;
  assign in_read = (state_q == ST_READ);
  assign in_wb   = (state_q == ST_WB);

  assign instr_ready = (state_q == ST_IDLE);
  assign rf_src_addr = in_read ? dec_src : 4'h0;
  assign rf_dst_addr = in_read ? dec_dst : 4'h0;

  assign fu_a   = fu_a_q;
  assign fu_b   = fu_b_q;
  assign fu_fs  = fu_fs_q;
  assign fu_bw  = fu_bw_q;
  assign fu_cin = fu_cin_q;

  assign rf_we    = in_wb & rf_wr_q;
  assign rf_waddr = in_wb ? waddr_q : 4'h0;
  assign rf_wdata = !in_wb ? '0 : (bw_q ? {{(SIZE-8){1'b0}}, f_q[7:0]} : f_q);
  assign sr_we    = in_wb & sr_wr_q;
  assign sr_cvnz  = in_wb ? cvnz_q : 4'h0;
  assign done     = in_wb & ~illegal_q;
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
  assign err      = (in_wb & illegal_q) | (state_q == ST_TRAP);
`else
  assign err      = in_wb & illegal_q;
`endif

endmodule

// File: tb/tb_func_seq.sv
// Scoreboard bench for func_seq: directed instruction vectors push expected
// write-back records; a negedge monitor pops and compares on each retire/err.
module tb_func_seq;

  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [15:0]     instr = '0;
  logic [3:0]      rf_src_addr, rf_dst_addr;
  logic [SIZE-1:0] rf_src_data, rf_dst_data;
  logic [SIZE-1:0] fu_a, fu_b;
  logic [5:0]      fu_fs;
  logic            fu_cin, fu_bw;
  logic [SIZE-1:0] fu_f = '0;
  logic [3:0]      fu_cvnz = '0;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [SIZE-1:0] rf_wdata;
  logic            sr_we;
  logic [3:0]      sr_cvnz;
  logic            sr_c = 1'b0;
  logic            done, err;

  func_seq #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_src_addr (rf_src_addr),
    .rf_dst_addr (rf_dst_addr),
    .rf_src_data (rf_src_data),
    .rf_dst_data (rf_dst_data),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_fs       (fu_fs),
    .fu_cin      (fu_cin),
    .fu_bw       (fu_bw),
    .fu_f        (fu_f),
    .fu_cvnz     (fu_cvnz),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .sr_we       (sr_we),
    .sr_cvnz     (sr_cvnz),
    .sr_c        (sr_c),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [15:0] rf_m [16];
  assign rf_src_data = rf_m[rf_src_addr];
  assign rf_dst_data = rf_m[rf_dst_addr];

  typedef struct packed {
    logic        rf_we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        sr_we;
    logic [3:0]  cvnz;
    logic        done;
    logic        err;
  } wb_t;

  typedef struct packed {
    logic [15:0] instr;
    logic        ill;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  fs;
    logic        bw;
    logic        sr_c;
    logic [15:0] f;
    logic [3:0]  cvnz;
    logic        rf_we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        sr_we;
  } vec_t;

  wb_t sb_q[$];
  wb_t mon_e;
  int  total = 0;
  int  bad = 0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any write pulse, done, or rising err is one retire event.
  always @(negedge clk) begin
    if (rst) begin
      err_prev = 1'b0;
    end else begin
      if (done || rf_we || sr_we || (err && !err_prev)) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wb: got rf_we=%b sr_we=%b done=%b err=%b expected no event",
                   rf_we, sr_we, done, err);
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_rf_we", rf_we, mon_e.rf_we);
          if (mon_e.rf_we) begin
            check("wb_waddr", rf_waddr, mon_e.waddr);
            check("wb_wdata", rf_wdata, mon_e.wdata);
          end
          check("wb_sr_we", sr_we, mon_e.sr_we);
          if (mon_e.sr_we) check("wb_sr_cvnz", sr_cvnz, mon_e.cvnz);
          check("wb_done", done, mon_e.done);
          check("wb_err", err, mon_e.err);
        end
      end
      err_prev = err;
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    check("ready_before", instr_ready, 1'b1);
    fu_f    = v.f;
    fu_cvnz = v.cvnz;
    sr_c    = v.sr_c;
    instr   = v.instr;
    instr_valid = 1'b1;
    if (v.ill) sb_q.push_back('{rf_we: 1'b0, waddr: 4'h0, wdata: 16'h0, sr_we: 1'b0,
                                cvnz: 4'h0, done: 1'b0, err: 1'b1});
    else       sb_q.push_back('{rf_we: v.rf_we, waddr: v.waddr, wdata: v.wdata, sr_we: v.sr_we,
                                cvnz: v.cvnz, done: 1'b1, err: 1'b0});
    @(posedge clk);
    #1;
    // Keep valid high with a junk word while busy: it must be ignored.
    instr = 16'h4F0F;
    @(negedge clk);
    check("ready_read", instr_ready, 1'b0);
    check("fu_a_read", fu_a, 16'h0);
    if (!v.ill) begin
      check("rf_src_addr", rf_src_addr, v.src);
      check("rf_dst_addr", rf_dst_addr, v.dst);
    end
    @(negedge clk);
    check("ready_exec", instr_ready, 1'b0);
    if (!v.ill) begin
      check("fu_a", fu_a, v.a);
      check("fu_b", fu_b, v.b);
      check("fu_fs", fu_fs, v.fs);
      check("fu_bw", fu_bw, v.bw);
      check("fu_cin", fu_cin, v.sr_c);
    end
    @(negedge clk);
    check("ready_wb", instr_ready, 1'b0);
    check("fu_fs_wb", fu_fs, 6'h0);
    instr_valid = 1'b0;
    @(negedge clk);
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
    if (v.ill) begin
      for (int i = 0; i < 3; i++) begin
        check("trap_err", err, 1'b1);
        check("trap_ready", instr_ready, 1'b0);
        @(negedge clk);
      end
      pulse_reset();
    end else begin
      check("ready_after", instr_ready, 1'b1);
    end
`else
    check("ready_after", instr_ready, 1'b1);
    check("err_after", err, 1'b0);
`endif
  endtask

  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
    rf_m[4] = 16'h1111;
    rf_m[5] = 16'h1234;
    rf_m[6] = 16'h0000;
    rf_m[7] = 16'h2222;
    rf_m[8] = 16'h8004;

    //          instr     ill   src   dst   a         b         fs     bw    sr_c  f         cvnz  rf_we waddr wdata     sr_we
    vecs[0] = '{16'h4506, 1'b0, 4'd5, 4'd6, 16'h1234, 16'h0000, 6'h04, 1'b0, 1'b1, 16'h1234, 4'h0, 1'b1, 4'd6, 16'h1234, 1'b0}; // MOV R5,R6
    vecs[1] = '{16'h5447, 1'b0, 4'd4, 4'd7, 16'h1111, 16'h2222, 6'h05, 1'b1, 1'b0, 16'hAB00, 4'h9, 1'b1, 4'd7, 16'h0000, 1'b1}; // ADD.B R4,R7
    vecs[2] = '{16'h9405, 1'b0, 4'd4, 4'd5, 16'h1111, 16'h1234, 6'h09, 1'b0, 1'b1, 16'hFEDD, 4'h2, 1'b0, 4'd5, 16'h0000, 1'b1}; // CMP R4,R5
    vecs[3] = '{16'h1108, 1'b0, 4'd8, 4'd8, 16'h8004, 16'h8004, 6'h22, 1'b0, 1'b0, 16'hC002, 4'h2, 1'b1, 4'd8, 16'hC002, 1'b1}; // RRA R8
    vecs[4] = '{16'h1085, 1'b0, 4'd5, 4'd5, 16'h1234, 16'h1234, 6'h21, 1'b0, 1'b1, 16'h3412, 4'h0, 1'b1, 4'd5, 16'h3412, 1'b0}; // SWPB R5
    vecs[5] = '{16'hB704, 1'b0, 4'd7, 4'd4, 16'h2222, 16'h1111, 6'h0B, 1'b0, 1'b0, 16'h0000, 4'h1, 1'b0, 4'd4, 16'h0000, 1'b1}; // BIT R7,R4
    vecs[6] = '{16'hE844, 1'b0, 4'd8, 4'd4, 16'h8004, 16'h1111, 6'h0E, 1'b1, 1'b1, 16'h9115, 4'h0, 1'b1, 4'd4, 16'h0015, 1'b1}; // XOR.B R8,R4
    vecs[7] = '{16'h4586, 1'b1, 4'd0, 4'd0, 16'h0,    16'h0,    6'h00, 1'b0, 1'b0, 16'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0}; // Ad=1
    vecs[8] = '{16'h1204, 1'b1, 4'd0, 4'd0, 16'h0,    16'h0,    6'h00, 1'b0, 1'b0, 16'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0}; // PUSH
    vecs[9] = '{16'h2000, 1'b1, 4'd0, 4'd0, 16'h0,    16'h0,    6'h00, 1'b0, 1'b0, 16'h0,    4'h0, 1'b0, 4'd0, 16'h0,    1'b0}; // JNE

    #2;
    check("rst_ready", instr_ready, 1'b1);
    check("rst_fu_a", fu_a, 16'h0);
    check("rst_fu_fs", fu_fs, 6'h0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(vecs[i]);

    // Reset during EXEC aborts the instruction without any write pulse.
    @(negedge clk);
    fu_f = 16'h3333;
    fu_cvnz = 4'h0;
    instr = 16'h5447;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_before_rst", fu_fs, 6'h05);
    rst = 1'b1;
    #1;
    check("abort_ready", instr_ready, 1'b1);
    check("abort_fu_a", fu_a, 16'h0);
    check("abort_fu_b", fu_b, 16'h0);
    check("abort_fu_fs", fu_fs, 6'h0);
    check("abort_fu_bw", fu_bw, 1'b0);
    check("abort_rf_we", rf_we, 1'b0);
    check("abort_sr_we", sr_we, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run(vecs[0]);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
